// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: opcodes, ALU functions,
// the FSM state type and the opcode-to-ALU-function mapping.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALTED,
    ST_FAULT
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_LW   = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_BEQ  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;

  // Address arithmetic (ADDI, LW, SW) shares the adder; BEQ compares by subtracting.
  function automatic logic [2:0] alu_op_for(input logic [2:0] opcode);
    logic [2:0] f;
    case (opcode)
      OP_SUB, OP_BEQ: f = ALU_SUB;
      OP_AND:         f = ALU_AND;
      default:        f = ALU_ADD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Memory request/acknowledge bus between the sequencer and unified memory.
interface multicycle_sequencer_if;
  logic memReq;
  logic memRead;
  logic memWrite;
  logic iorD;
  logic memAck;

  modport master (output memReq, output memRead, output memWrite, output iorD,
                  input  memAck);
  modport slave  (input  memReq, input  memRead, input  memWrite, input  iorD,
                  output memAck);
endinterface

// File: rtl/multicycle_sequencer_wait_timer.sv
// Counts cycles spent waiting for a memory acknowledge; flags expiry once
// the count reaches maxWait. Holds at maxWait rather than wrapping.
module seq_wait_timer #(
  parameter int waitBits = 4,
  parameter int maxWait  = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_count,
  input  logic i_clear,
  output logic o_expired
);

  logic [waitBits-1:0] r_waitCnt;

  // Wait counter: clear has priority over counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_waitCnt <= '0;
    end else if (i_clear) begin
      r_waitCnt <= '0;
    end else if (i_count && !o_expired) begin
      r_waitCnt <= r_waitCnt + 1'b1;
    end
  end

  assign o_expired = (r_waitCnt == waitBits'(maxWait));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: steps the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB, handshakes with memory, detects memory timeouts
// and counts retired instructions.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int opwidth    = 3,
  parameter int mcodebits  = 3,
  parameter int waitBits   = 4,
  parameter int maxWait    = 15,
  parameter int countWidth = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [mcodebits-1:0]   instruction,
  input  logic                   zero,
  multicycle_sequencer_if.master mem,
  output logic                   irWrite,
  output logic                   pcWrite,
  output logic                   pcSrc,
  output logic                   aluSrc,
  output logic [opwidth-1:0]     aluOp,
  output logic                   regWrite,
  output logic                   memToReg,
  output logic                   busy,
  output logic                   halted,
  output logic                   fault,
  output logic [countWidth-1:0]  instrCount
);

  state_t                r_state;
  state_t                w_next;
  logic [countWidth-1:0] r_instrCount;
  logic                  w_retire;
  logic                  w_memPhase;
  logic                  w_expired;
  logic                  w_timeout;

  assign w_memPhase = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_timeout  = w_memPhase && w_expired && !mem.memAck;

  seq_wait_timer #(
    .waitBits (waitBits),
    .maxWait  (maxWait)
  ) u_wait_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_count   (w_memPhase && !mem.memAck),
    .i_clear   ((w_memPhase && mem.memAck) || (w_next != r_state)),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instrCount <= '0;
    end else if (w_retire) begin
      r_instrCount <= r_instrCount + 1'b1;
    end
  end

  assign instrCount = r_instrCount;

  // Next-state and datapath strobes from the current state; a timeout wins over everything.
  always_comb begin
    w_next       = r_state;
    w_retire     = 1'b0;
    mem.memReq   = 1'b0;
    mem.memRead  = 1'b0;
    mem.memWrite = 1'b0;
    mem.iorD     = 1'b0;
    irWrite      = 1'b0;
    pcWrite      = 1'b0;
    pcSrc        = 1'b0;
    aluSrc       = 1'b0;
    aluOp        = '0;
    regWrite     = 1'b0;
    memToReg     = 1'b0;
    busy         = 1'b0;
    halted       = 1'b0;
    fault        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        busy        = 1'b1;
        mem.memReq  = 1'b1;
        mem.memRead = 1'b1;
        if (w_timeout) begin
          w_next = ST_FAULT;
        end else if (mem.memAck) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          w_next  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        busy = 1'b1;
        if (instruction == OP_HALT) begin
          w_retire = 1'b1;
          w_next   = ST_HALTED;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        busy   = 1'b1;
        aluOp  = opwidth'(alu_op_for(instruction));
        aluSrc = (instruction == OP_ADDI) || (instruction == OP_LW) ||
                 (instruction == OP_SW);
        case (instruction)
          OP_LW, OP_SW: w_next = ST_MEM;
          OP_BEQ: begin
            pcWrite  = zero;
            pcSrc    = 1'b1;
            w_retire = 1'b1;
            w_next   = ST_FETCH;
          end
          default: w_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        busy         = 1'b1;
        mem.memReq   = 1'b1;
        mem.iorD     = 1'b1;
        aluSrc       = 1'b1;
        mem.memRead  = (instruction == OP_LW);
        mem.memWrite = (instruction == OP_SW);
        if (w_timeout) begin
          w_next = ST_FAULT;
        end else if (mem.memAck) begin
          if (instruction == OP_SW) begin
            w_retire = 1'b1;
            w_next   = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        busy     = 1'b1;
        regWrite = 1'b1;
        memToReg = (instruction == OP_LW);
        w_retire = 1'b1;
        w_next   = ST_FETCH;
      end
      ST_HALTED: halted = 1'b1;
      ST_FAULT:  fault  = 1'b1;
      default:   w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed and randomized instruction streams
// compared cycle by cycle against a phase-schedule reference model.
module tb_multicycle_sequencer;

  localparam int MAXW = 15;

  // Phase identifiers used only by the reference model.
  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_EXEC = 3,
                 PH_MEM = 4, PH_WB = 5, PH_HALTED = 6, PH_FAULT = 7;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  instruction;
  logic        zero;
  logic        irWrite, pcWrite, pcSrc, aluSrc, regWrite, memToReg;
  logic        busy, halted, fault;
  logic [2:0]  aluOp;
  logic [15:0] instrCount;

  multicycle_sequencer_if mem_if ();

  multicycle_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .instruction (instruction),
    .zero        (zero),
    .mem         (mem_if),
    .irWrite     (irWrite),
    .pcWrite     (pcWrite),
    .pcSrc       (pcSrc),
    .aluSrc      (aluSrc),
    .aluOp       (aluOp),
    .regWrite    (regWrite),
    .memToReg    (memToReg),
    .busy        (busy),
    .halted      (halted),
    .fault       (fault),
    .instrCount  (instrCount)
  );

  always #5 clk = ~clk;

  wire [15:0] w_obs = {mem_if.memReq, mem_if.memRead, mem_if.memWrite, mem_if.iorD,
                       irWrite, pcWrite, pcSrc, aluSrc, aluOp,
                       regWrite, memToReg, busy, halted, fault};

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected strobe vector for one cycle, straight from the per-phase strobe table.
  function automatic logic [15:0] exp_vec(input int ph, input logic [2:0] op,
                                          input logic ack, input logic z);
    logic req, rd, wr, ad, ir, pcw, pcs, asrc, rw, m2r, bsy, hlt, flt;
    logic [2:0] alu;
    {req, rd, wr, ad, ir, pcw, pcs, asrc, rw, m2r, bsy, hlt, flt} = '0;
    alu = 3'b000;
    case (ph)
      PH_FETCH: begin
        req = 1; rd = 1; bsy = 1;
        if (ack) begin ir = 1; pcw = 1; end
      end
      PH_DECODE: bsy = 1;
      PH_EXEC: begin
        bsy = 1;
        if (op == 3'd1 || op == 3'd5) alu = 3'b001;
        else if (op == 3'd6)          alu = 3'b010;
        asrc = (op == 3'd2 || op == 3'd3 || op == 3'd4);
        if (op == 3'd5) begin pcw = z; pcs = 1; end
      end
      PH_MEM: begin
        bsy = 1; req = 1; ad = 1; asrc = 1;
        rd = (op == 3'd3); wr = (op == 3'd4);
      end
      PH_WB: begin
        bsy = 1; rw = 1; m2r = (op == 3'd3);
      end
      PH_HALTED: hlt = 1;
      PH_FAULT:  flt = 1;
      default: ;
    endcase
    return {req, rd, wr, ad, ir, pcw, pcs, asrc, alu, rw, m2r, bsy, hlt, flt};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 ns later, wait for the next falling edge.
  task automatic cyc(input int ph, input logic [2:0] op, input logic ack,
                     input logic z, input string tag);
    mem_if.memAck = ack;
    zero          = z;
    instruction   = op;
    #1;
    check(tag, 32'(w_obs), 32'(exp_vec(ph, op, ack, z)));
    @(negedge clk);
  endtask

  // Full instruction starting in its first FETCH cycle; dF/dM are memory wait cycles.
  task automatic run_instr(input logic [2:0] op, input int dF, input int dM, input logic z);
    #1;
    check("count", 32'(instrCount), 32'(exp_count));
    for (int i = 0; i <= dF; i++) cyc(PH_FETCH, op, (i == dF), rbit(), "fetch");
    cyc(PH_DECODE, op, rbit(), rbit(), "decode");
    if (op == 3'd7) begin exp_count++; return; end
    cyc(PH_EXEC, op, rbit(), (op == 3'd5) ? z : rbit(), "exec");
    if (op == 3'd5) begin exp_count++; return; end
    if (op == 3'd3 || op == 3'd4) begin
      for (int i = 0; i <= dM; i++) cyc(PH_MEM, op, (i == dM), rbit(), "mem");
      if (op == 3'd4) begin exp_count++; return; end
    end
    cyc(PH_WB, op, rbit(), rbit(), "wb");
    exp_count++;
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 7) == 0) ? MAXW : int'($urandom_range(0, 3));
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("reset_vec", 32'(w_obs), 32'd0);
    check("reset_cnt", 32'(instrCount), 32'd0);
    exp_count = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic leave_idle();
    start = 1'b1;
    cyc(PH_IDLE, 3'd0, rbit(), rbit(), "idle_start");
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; zero = 1'b0; instruction = 3'd0;
    mem_if.memAck = 1'b0; exp_count = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // Idle holds without start.
    cyc(PH_IDLE, 3'd0, 1'b1, rbit(), "idle_hold");
    leave_idle();

    // Directed: ADD zero-wait, LW with 3 wait cycles, BEQ taken and not taken.
    run_instr(3'd0, 0, 0, 1'b0);
    run_instr(3'd3, 0, 3, 1'b0);
    run_instr(3'd5, 0, 0, 1'b1);
    run_instr(3'd5, 0, 0, 1'b0);
    run_instr(3'd4, 1, 0, 1'b0);

    // Randomized instruction stream (no HALT).
    for (int n = 0; n < 40; n++)
      run_instr(3'($urandom_range(0, 6)), rand_wait(), rand_wait(), rbit());

    // Two ADDs then HALT, with start pulses ignored while halted.
    run_instr(3'd0, 0, 0, 1'b0);
    run_instr(3'd0, 0, 0, 1'b0);
    run_instr(3'd7, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      start = rbit();
      cyc(PH_HALTED, 3'($urandom_range(0, 7)), rbit(), rbit(), "halted");
    end
    start = 1'b0;
    #1 check("halt_cnt", 32'(instrCount), 32'(exp_count));
    @(negedge clk);
    do_reset();

    // Fetch timeout: no acknowledge for maxWait+1 fetch cycles, then fault is sticky.
    leave_idle();
    for (int i = 0; i <= MAXW; i++) cyc(PH_FETCH, 3'd0, 1'b0, rbit(), "fetch_wait");
    for (int i = 0; i < 5; i++) begin
      start = rbit();
      cyc(PH_FAULT, 3'($urandom_range(0, 7)), rbit(), rbit(), "fault");
    end
    start = 1'b0;
    #1 check("fault_cnt", 32'(instrCount), 32'd0);
    @(negedge clk);
    do_reset();

    // Reset asserted while an SW is waiting in MEM.
    leave_idle();
    cyc(PH_FETCH, 3'd4, 1'b1, 1'b0, "sw_fetch");
    cyc(PH_DECODE, 3'd4, 1'b0, 1'b0, "sw_decode");
    cyc(PH_EXEC, 3'd4, 1'b0, 1'b0, "sw_exec");
    cyc(PH_MEM, 3'd4, 1'b0, 1'b0, "sw_mem0");
    cyc(PH_MEM, 3'd4, 1'b0, 1'b0, "sw_mem1");
    mem_if.memAck = 1'b0;
    do_reset();
    cyc(PH_IDLE, 3'd4, 1'b1, 1'b0, "post_reset_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle FSM that sequences the single shared datapath (ALU, register file, unified instruction/data memory) one instruction at a time. Takes the 3-bit opcode from the instruction register and drives per-state datapath strobes, with a req/ack handshake to memory. Replaces fixed per-opcode decode with a FETCH/DECODE/EXEC/MEM/WB schedule, plus memory timeout fault detection and a retired-instruction counter.

Parameters:
opwidth, 3, width of aluOp
mcodebits, 3, opcode width
waitBits, 4, width of memory wait counter
maxWait, 15, cycles without memAck before fault (must be < 2^waitBits)
countWidth, 16, retired-instruction counter width

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  leave IDLE and begin fetching
instruction  in  mcodebits  opcode from the instruction register
zero  in  1  ALU zero flag
memAck  in  1  memory completed the current request
memReq  out  1  memory request, held until memAck
memRead  out  1  read access
memWrite  out  1  write access
iorD  out  1  0 = address from PC, 1 = address from ALU result
irWrite  out  1  load the instruction register
pcWrite  out  1  load the PC
pcSrc  out  1  0 = PC+1, 1 = branch target
aluSrc  out  1  ALU B operand is the immediate
aluOp  out  opwidth  ALU function
regWrite  out  1  register file write enable
memToReg  out  1  write-back data comes from memory
busy  out  1  FSM is not in IDLE, HALTED or FAULT
halted  out  1  HALT opcode retired
fault  out  1  memory timeout occurred
instrCount  out  countWidth  count of retired instructions

Behaviour:
- Opcodes: 000 ADD, 001 SUB, 010 ADDI, 011 LW, 100 SW, 101 BEQ, 110 AND, 111 HALT.
- aluOp values: ADD 000, SUB 001, AND 010. ADDI, LW and SW use ADD. BEQ uses SUB.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, FAULT.
- Reset (asynchronous, reset_n=0): state goes to IDLE; all strobes 0; aluOp 000; instrCount 0; waitCnt 0; halted, fault and busy all 0.
- Strobes are combinational from the registered state, instruction, memAck and zero. Any strobe not listed for a state is 0.
- IDLE: go to FETCH when start=1; otherwise stay.
- FETCH: memReq=1, memRead=1, iorD=0.
  - If memAck=1 in the same cycle: irWrite=1, pcWrite=1, pcSrc=0; next state DECODE.
- DECODE: one cycle, no strobes.
  - instruction=111: go to HALTED and increment instrCount.
  - Any other opcode: go to EXEC.
- EXEC: drive aluOp for the opcode; aluSrc=1 for ADDI, LW and SW.
  - ADD, SUB, AND, ADDI: go to WB.
  - LW, SW: go to MEM.
  - BEQ: pcWrite=zero, pcSrc=1; increment instrCount; go to FETCH.
- MEM: memReq=1, iorD=1, aluSrc=1, aluOp=000; memRead=1 for LW, memWrite=1 for SW. Wait for memAck.
  - On memAck with SW: increment instrCount; go to FETCH.
  - On memAck with LW: go to WB.
- WB: regWrite=1; memToReg=1 only for LW; increment instrCount; go to FETCH.
- Memory handshake:
  - memReq stays asserted and the address select stays stable until memAck.
  - memAck outside FETCH/MEM is ignored.
- Latency with zero-wait memory (memAck in the request cycle):
  - ALU ops and ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - HALT: 2 cycles.
  - Each memory wait cycle adds 1.
- Wait counter:
  - waitCnt increments each cycle in FETCH or MEM without memAck.
  - It clears on memAck and on every state change.
  - When waitCnt reaches maxWait with memAck=0: go to FAULT; the transition takes priority over everything else that cycle.
- HALTED: halted=1; start is ignored; exit only by reset.
- FAULT: fault=1; start and memAck are ignored; exit only by reset.
- instrCount wraps from 2^countWidth-1 to 0 with no flag.
- busy=1 in FETCH, DECODE, EXEC, MEM and WB.
- Reset asserted mid-instruction: the next cycle shows all strobes 0 and state IDLE, including during an outstanding memReq. Memory must drop the request.

Decomposition:
- Shared package: opcode constants, aluOp constants, and the state enum typedef.
- Sub-module seq_wait_timer: holds waitCnt, with inputs count/clear and output expired. The FSM stays in the top module.

Test Plan:
- Reset then start=1, instruction=000, memAck tied 1 -> exactly 4 busy cycles; regWrite=1 and aluOp=000 in cycle 4; instrCount=1.
- LW (011) with memAck delayed 3 cycles in MEM -> memReq and memRead held for 4 cycles with iorD=1; then WB with memToReg=1 and regWrite=1.
- BEQ (101) with zero=1, then again with zero=0 -> EXEC shows pcWrite=1 and pcSrc=1 the first time; the second time pcWrite=0; each takes 3 cycles.
- FETCH with memAck held 0 -> fault=1 after 15 wait cycles; busy=0; later memAck or start pulses change nothing.
- HALT (111) after 2 ADDs -> halted=1, instrCount=3; start pulses ignored; reset_n=0 clears halted and instrCount.
- Assert reset_n=0 mid-MEM of an SW -> memWrite and memReq drop immediately; state IDLE; instrCount unchanged from its pre-reset reset value, which is 0.
